// File: rtl/pixie_dma_scheduler.sv
// pixie_dma_scheduler
//   Frame/line timing and DMA sequencer for an 1861-style display path.
//   Keeps the machine-cycle position inside a 262-line frame and drives
//   DMAO, INT and EFx toward the CDP1802. Each DMA-out cycle the CPU grants
//   (SC=2'b10) becomes a one-clock frame-buffer write strobe with its address.
//   Every state change happens only on a clock where clk_enable is high,
//   which marks one 1802 machine cycle.
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   clk_enable   machine-cycle strobe
//   SC           1802 state code (2'b10 DMA cycle, 2'b11 interrupt acknowledge)
//   disp_on      display enable request; also clears underrun
//   disp_off     display disable request; wins over disp_on
//   DMAO         DMA-out request, active low
//   INT          interrupt request, active high
//   EFx          display flag, active low
//   mem_addr     RAM address of the next DMA byte on the current line
//   fb_we        one-clock write strobe per accepted DMA byte
//   fb_waddr     frame-buffer byte address, {row, byte}
//   frame_start  one-clock pulse as the position wraps to line 0, cycle 0
//   underrun     sticky flag: a line ended short of DMA_BYTES transfers
//   state_dbg    current sequencer state (0 idle, 1 wait, 2 request)
//
// Handshake: DMAO low means a request is pending. A byte counts as
// transferred only on a clk_enable clock with SC==2'b10 while the request
// is pending. SC==2'b10 at any other time is ignored.
module pixie_dma_scheduler #(
  parameter int          CYCLES_PER_LINE = 14,
  parameter int          LINES_PER_FRAME = 262,
  parameter int          ACTIVE_FIRST    = 64,
  parameter int          ACTIVE_LINES    = 128,
  parameter int          INT_LINE        = 62,
  parameter int          EF_LEAD         = 4,
  parameter int          DMA_START       = 2,
  parameter int          DMA_LIMIT       = 10,
  parameter int          DMA_BYTES       = 8,
  parameter int          LINE_REPEAT     = 4,
  parameter logic [15:0] BASE_ADDR       = 16'h0900
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  SC,
  input  logic        disp_on,
  input  logic        disp_off,
  output logic        DMAO,
  output logic        INT,
  output logic        EFx,
  output logic [15:0] mem_addr,
  output logic        fb_we,
  output logic [7:0]  fb_waddr,
  output logic        frame_start,
  output logic        underrun,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  h_cnt;
  logic [8:0]  v_cnt;
  logic [3:0]  byte_cnt, byte_cnt_d;
  logic        display_en, en_d;
  logic        int_done;
  logic        dmao_d, we_d, underrun_d;
  logic [15:0] mem_addr_d;
  logic [7:0]  waddr_d;

  logic        h_last, v_last, active, ef_low, int_win;
  logic [8:0]  v_off;
  logic [4:0]  row;

  assign h_last  = (h_cnt == 4'(CYCLES_PER_LINE - 1));
  assign v_last  = (v_cnt == 9'(LINES_PER_FRAME - 1));
  assign active  = (v_cnt >= 9'(ACTIVE_FIRST)) && (v_cnt < 9'(ACTIVE_FIRST + ACTIVE_LINES));
  assign v_off   = v_cnt - 9'(ACTIVE_FIRST);
  assign row     = 5'(v_off / 9'(LINE_REPEAT));
  assign ef_low  = ((v_cnt >= 9'(ACTIVE_FIRST - EF_LEAD)) && (v_cnt < 9'(ACTIVE_FIRST))) ||
                   ((v_cnt >= 9'(ACTIVE_FIRST + ACTIVE_LINES - EF_LEAD)) &&
                    (v_cnt < 9'(ACTIVE_FIRST + ACTIVE_LINES)));
  assign int_win = (v_cnt == 9'(INT_LINE)) || (v_cnt == 9'(INT_LINE + 1));

  assign state_dbg = state_q;

  // Next-state and next-output logic; everything below is registered.
  always_comb begin
    state_d    = state_q;
    en_d       = display_en;
    byte_cnt_d = byte_cnt;
    mem_addr_d = mem_addr;
    waddr_d    = fb_waddr;
    underrun_d = underrun;
    we_d       = 1'b0;
    dmao_d     = 1'b1;

    if (disp_off) begin
      en_d = 1'b0;
    end else if (disp_on) begin
      en_d       = 1'b1;
      underrun_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (en_d) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (active && (h_cnt == 4'(DMA_START))) begin
          byte_cnt_d = 4'd0;
          mem_addr_d = BASE_ADDR + {8'd0, row, 3'b000};
          dmao_d     = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        dmao_d = 1'b0;
        if (SC == 2'b10) begin
          we_d       = 1'b1;
          waddr_d    = {row, byte_cnt[2:0]};
          byte_cnt_d = byte_cnt + 4'd1;
          mem_addr_d = mem_addr + 16'd1;
        end
        // A transfer on the limit cycle that completes the line beats the
        // underrun check.
        if ((SC == 2'b10) && (byte_cnt == 4'(DMA_BYTES - 1))) begin
          dmao_d  = 1'b1;
          state_d = S_WAIT;
        end else if (h_cnt == 4'(DMA_LIMIT)) begin
          underrun_d = 1'b1;
          dmao_d     = 1'b1;
          state_d    = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disabling drops the line in progress on the same machine cycle.
    if (!en_d) begin
      state_d    = S_IDLE;
      dmao_d     = 1'b1;
      we_d       = 1'b0;
      waddr_d    = fb_waddr;
      byte_cnt_d = byte_cnt;
      mem_addr_d = mem_addr;
      underrun_d = underrun;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      h_cnt       <= 4'd0;
      v_cnt       <= 9'd0;
      byte_cnt    <= 4'd0;
      display_en  <= 1'b0;
      int_done    <= 1'b0;
      DMAO        <= 1'b1;
      INT         <= 1'b0;
      EFx         <= 1'b1;
      mem_addr    <= BASE_ADDR;
      fb_we       <= 1'b0;
      fb_waddr    <= 8'd0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      fb_we       <= 1'b0;
      frame_start <= 1'b0;
      if (clk_enable) begin
        state_q    <= state_d;
        display_en <= en_d;
        byte_cnt   <= byte_cnt_d;
        mem_addr   <= mem_addr_d;
        fb_waddr   <= waddr_d;
        fb_we      <= we_d;
        underrun   <= underrun_d;
        DMAO       <= dmao_d;
        EFx        <= ~ef_low;

        // Position counters free-run regardless of display enable.
        h_cnt <= h_last ? 4'd0 : h_cnt + 4'd1;
        if (h_last) v_cnt <= v_last ? 9'd0 : v_cnt + 9'd1;
        frame_start <= h_last && v_last;

        // An acknowledge inside the window retires INT for the rest of the frame.
        if (h_last && v_last) begin
          int_done <= 1'b0;
        end else if (int_win && (SC == 2'b11)) begin
          int_done <= 1'b1;
        end
        INT <= display_en && int_win && !int_done && (SC != 2'b11);
      end
    end
  end

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
module tb_pixie_dma_scheduler;

  localparam int FRAME = 262 * 14;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_enable = 1'b1;
  logic [1:0]  sc = 2'b00;
  logic        disp_on = 1'b0;
  logic        disp_off = 1'b0;
  logic        dmao, int_o, efx, fb_we, frame_start, underrun;
  logic [15:0] mem_addr;
  logic [7:0]  fb_waddr;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  pixie_dma_scheduler dut (
    .clk         (clk),
    .reset       (rst),
    .clk_enable  (clk_enable),
    .SC          (sc),
    .disp_on     (disp_on),
    .disp_off    (disp_off),
    .DMAO        (dmao),
    .INT         (int_o),
    .EFx         (efx),
    .mem_addr    (mem_addr),
    .fb_we       (fb_we),
    .fb_waddr    (fb_waddr),
    .frame_start (frame_start),
    .underrun    (underrun),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          n = 0;          // machine cycles since reset release
  int          we_cnt = 0;
  int          fs_cnt = 0;
  logic [7:0]  last_waddr = 8'd0;
  bit          auto_exp = 1'b0;
  logic [23:0] exp_q[$];       // {fb_waddr, mem_addr after the accepted byte}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (line %0d cycle %0d)", name, act, exp,
               (n / 14) % 262, n % 14);
    end
  endtask

  function automatic int cur_h();
    return n % 14;
  endfunction

  function automatic int cur_v();
    return (n / 14) % 262;
  endfunction

  // Push the eight writes a full-rate line should produce.
  task automatic push_line(input int v);
    int row;
    row = (v - 64) / 4;
    for (int b = 0; b < 8; b++)
      exp_q.push_back({8'(row * 8 + b), 16'(16'h0900 + row * 8 + b + 1)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    if (auto_exp && clk_enable && cur_h() == 2 && cur_v() >= 64 && cur_v() < 192)
      push_line(cur_v());
    @(posedge clk);
    #1;
    if (clk_enable) n++;
  endtask

  task automatic run_to(input int v, input int h);
    int i;
    i = 0;
    while (!(cur_v() == v && cur_h() == h) && i < FRAME + 2) begin
      step();
      i++;
    end
    check("run_to_reached", (cur_v() == v && cur_h() == h), 1);
  endtask

  task automatic pulse_on();
    disp_on = 1'b1;
    step();
    disp_on = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_DMAO"}, dmao, 1);
    check({tag, "_INT"}, int_o, 0);
    check({tag, "_EFx"}, efx, 1);
    check({tag, "_mem_addr"}, mem_addr, 32'h0900);
    check({tag, "_fb_we"}, fb_we, 0);
    check({tag, "_fb_waddr"}, fb_waddr, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [23:0] e;
    #2;
    if (!rst && fb_we) begin
      if (exp_q.size() == 0) begin
        check("fb_we_unexpected", {fb_waddr, mem_addr}, 0);
      end else begin
        e = exp_q.pop_front();
        check("fb_write", {8'd0, fb_waddr, mem_addr}, {8'd0, e});
      end
      we_cnt++;
      last_waddr = fb_waddr;
    end
    if (!rst && frame_start) begin
      fs_cnt++;
      check("frame_start_position", n % FRAME, 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int low_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    check_reset_values("por");

    // Reset while a line fetch is part way through (byte 3 pending).
    pulse_on();
    sc = 2'b10;
    auto_exp = 1'b1;
    run_to(64, 6);
    check("midreq_DMAO", dmao, 0);
    check("midreq_mem_addr", mem_addr, 32'h0903);
    #2 rst = 1'b1;
    #1 check_reset_values("midreq_rst");
    exp_q.delete();
    auto_exp = 1'b0;
    sc = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    we_cnt = 0;
    fs_cnt = 0;

    // Frame A: full-rate DMA, EFx and INT timing.
    pulse_on();
    sc = 2'b10;
    auto_exp = 1'b1;
    run_to(60, 0);
    check("ef_before_60", efx, 1);
    step();
    check("ef_line_60", efx, 0);
    run_to(62, 0);
    check("int_before_62", int_o, 0);
    step();
    check("int_line_62", int_o, 1);
    run_to(64, 0);
    check("int_end_63", int_o, 1);
    check("ef_end_63", efx, 0);
    step();
    check("int_after_63", int_o, 0);
    check("ef_line_64", efx, 1);
    run_to(64, 2);
    check("dmao_before_start", dmao, 1);
    step();
    check("dmao_at_start", dmao, 0);
    check("mem_addr_row0", mem_addr, 32'h0900);
    low_cnt = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dmao == 1'b0) low_cnt++;
    end
    check("dmao_low_cycles", low_cnt, 8);
    check("dmao_released", dmao, 1);
    run_to(68, 2);
    step();
    check("mem_addr_row1", mem_addr, 32'h0908);
    run_to(188, 0);
    check("ef_before_188", efx, 1);
    step();
    check("ef_line_188", efx, 0);
    run_to(192, 0);
    check("ef_end_191", efx, 0);
    step();
    check("ef_line_192", efx, 1);
    check("frame_write_count", we_cnt, 1024);
    check("last_fb_waddr", last_waddr, 255);
    check("no_underrun_full_rate", underrun, 0);
    run_to(0, 0);
    check("frame_start_pulse", frame_start, 1);
    step();
    check("frame_start_one_clk", frame_start, 0);
    auto_exp = 1'b0;
    sc = 2'b00;

    // Frame B: interrupt acknowledge, short line, gating, disable.
    run_to(62, 3);
    check("int_before_ack", int_o, 1);
    sc = 2'b11;
    step();
    sc = 2'b00;
    check("int_ack_drop", int_o, 0);
    run_to(64, 0);
    check("int_stays_low", int_o, 0);
    run_to(64, 2);
    step();
    for (int b = 0; b < 5; b++)
      exp_q.push_back({8'(b), 16'(16'h0901 + b)});
    sc = 2'b10;
    repeat (5) step();
    clk_enable = 1'b0;
    repeat (3) step();
    clk_enable = 1'b1;
    sc = 2'b00;
    check("gated_no_writes", we_cnt, 1029);
    run_to(64, 10);
    check("short_line_dmao", dmao, 0);
    check("short_line_no_underrun_yet", underrun, 0);
    step();
    check("limit_dmao", dmao, 1);
    check("limit_underrun", underrun, 1);
    pulse_on();
    check("disp_on_clears_underrun", underrun, 0);
    run_to(100, 4);
    check("line100_dmao", dmao, 0);
    disp_off = 1'b1;
    step();
    disp_off = 1'b0;
    check("disp_off_dmao", dmao, 1);
    check("disp_off_idle", state_dbg, 0);
    run_to(104, 4);
    check("disabled_dmao", dmao, 1);
    disp_on = 1'b1;
    disp_off = 1'b1;
    step();
    disp_on = 1'b0;
    disp_off = 1'b0;
    run_to(108, 4);
    check("on_off_disable_dmao", dmao, 1);
    check("short_line_writes", we_cnt, 1029);
    check("queue_drained", exp_q.size(), 0);
    check("frame_start_count", fs_cnt, n / FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
